// File: rtl/coord_enc144.sv
// coord_enc144: sequential coordinate encoder for a 12x12 tile.
// It loads a 144-bit occupancy mask on start and then emits the (x_cor, y_cor)
// of every set bit in ascending bit order, one per cycle, over a valid/ready
// stream. Bit i maps to x = i mod 12 and y = i div 12.
// Ports:
//   clk, rst_n           clock and asynchronous active-low reset
//   start, mask          load mask and begin a scan (honoured only in IDLE)
//   busy                 high while scanning (RUN)
//   out_valid, out_ready output handshake
//   x_cor, y_cor, last   coordinate payload; last marks the final entry
//   done                 one-cycle pulse when the scan completes
//   count                number of entries accepted in the current or last scan
module coord_enc144 (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [143:0]         mask,
   output logic                 busy,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [3:0]           x_cor,
   output logic [3:0]           y_cor,
   output logic                 last,
   output logic                 done,
   output logic [7:0]           count
);

   localparam int unsigned NPOS  = 144;
   localparam int unsigned GRID  = 12;
   localparam int unsigned IDX_W = 8;
   localparam int unsigned CRD_W = 4;
   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t             state, state_d;
   logic [NPOS-1:0]    pending, pending_d;
   logic [NPOS-1:0]    pending_clr;
   logic [IDX_W-1:0]   low_idx;
   logic [CRD_W-1:0]   row, col;
   logic               free;
   logic               out_valid_d, last_d, busy_d, done_d;
   logic [CRD_W-1:0]   x_d, y_d;
   logic [CNT_W-1:0]   count_d;

   // Lowest set bit of pending; scanning downward lets the lowest index win.
   always_comb begin
      low_idx = '0;
      for (int i = NPOS - 1; i >= 0; i--) begin
         if (pending[i]) low_idx = IDX_W'(i);
      end
   end

   // pending with its lowest set bit cleared.
   assign pending_clr = pending & (pending - NPOS'(1));

   // Row = idx div 12 by threshold compare; column is the remainder.
   always_comb begin
      row = '0;
      for (int r = 1; r < int'(GRID); r++) begin
         if (low_idx >= IDX_W'(r * int'(GRID))) row = CRD_W'(r);
      end
      col = CRD_W'(low_idx - IDX_W'(IDX_W'(row) * IDX_W'(GRID)));
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d     = state;
      pending_d   = pending;
      out_valid_d = out_valid;
      x_d         = x_cor;
      y_d         = y_cor;
      last_d      = last;
      count_d     = count;
      free        = !out_valid || out_ready;

      case (state)
         IDLE: begin
            if (start) begin
               pending_d = mask;
               count_d   = '0;
               state_d   = RUN;
            end
         end
         RUN: begin
            if (out_valid && out_ready) count_d = count + CNT_W'(1);
            if (free) begin
               if (pending != '0) begin
                  x_d         = col;
                  y_d         = row;
                  last_d      = (pending_clr == '0);
                  out_valid_d = 1'b1;
                  pending_d   = pending_clr;
               end else begin
                  out_valid_d = 1'b0;
                  state_d     = FIN;
               end
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
         end
      endcase

      busy_d = (state_d == RUN);
      done_d = (state_d == FIN);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         pending   <= '0;
         out_valid <= 1'b0;
         x_cor     <= '0;
         y_cor     <= '0;
         last      <= 1'b0;
         count     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_d;
         pending   <= pending_d;
         out_valid <= out_valid_d;
         x_cor     <= x_d;
         y_cor     <= y_d;
         last      <= last_d;
         count     <= count_d;
         busy      <= busy_d;
         done      <= done_d;
      end
   end

endmodule
